in_service_control: RTL and testbench
=====================================

Name: in_service_control

Overview:
- Downstream neighbour of the priority resolver in the 8259A-compatible controller.
- Takes the resolver's one-hot highest-priority request, compares it against the in-service register (ISR) under fully nested priority, and raises INT to the CPU.
- Runs the two-pulse 8086 INTA sequence: sets the ISR bit, tells the IRR stage to clear the request, and drives the interrupt vector.
- Handles specific and non-specific EOI.

Parameters:
- INTA_SYNC_STAGES, 2: flip-flop stages that synchronise the asynchronous inta_n pin. Legal values are 2 or 3.
- SPURIOUS_LEVEL, 7: IR level placed in the vector when a request vanishes before the first INTA.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- interrupt  in  8  one-hot resolved request from the priority resolver; 8'h00 = none. Bit 0 is highest priority.
- vector_base  in  5  T7..T3 of the vector (ICW2).
- inta_n  in  1  CPU interrupt acknowledge, active-low, asynchronous.
- eoi_nonspecific  in  1  one-cycle pulse: clear the highest-priority ISR bit.
- eoi_specific  in  1  one-cycle pulse: clear ISR[eoi_level].
- eoi_level  in  3  target level for eoi_specific.
- int_out  out  1  INT to the CPU.
- in_service_register  out  8  current ISR; also feeds the resolver.
- clear_interrupt_request  out  8  one-cycle one-hot pulse to the IRR stage.
- freeze  out  1  high from the first INTA falling edge until the end of the sequence; the IRR stage holds its contents while high.
- data_out  out  8  vector byte.
- data_out_en  out  1  data bus drive enable.

Behaviour:
- Reset: all outputs 0, ISR = 8'h00, state = IDLE, synchroniser flops = 1. Reset mid-sequence aborts the sequence immediately, with no clear pulse and no vector.
- inta_n passes through INTA_SYNC_STAGES flops, then one edge-detect flop.
  - fall = previous 1 and current 0; rise = previous 0 and current 1.
  - Pin-to-detected-edge latency is INTA_SYNC_STAGES+1 cycles.
- Priority: level L = index of the set bit in interrupt. Request is eligible when interrupt != 0 and no ISR bit with index <= L is set.
- States: IDLE, PENDING, ACK1, ACK2.
- IDLE:
  - Eligible request: go to PENDING and set int_out=1 on the next cycle.
  - A fall while in IDLE is ignored.
- PENDING:
  - Request is not rechecked; int_out stays 1 until fall.
  - On fall: latch L, set ISR[L], pulse clear_interrupt_request = interrupt for one cycle, set freeze=1 and int_out=0, go to ACK1.
  - If interrupt == 0 at fall: latch SPURIOUS_LEVEL, set no ISR bit, pulse nothing.
- ACK1:
  - On rise: go to ACK2.
  - A second fall before a rise cannot occur; there is no error state.
- ACK2:
  - On fall: data_out = {vector_base, latched level}, data_out_en=1.
  - Both are held while the synchronised inta_n is low.
  - On rise: data_out_en=0, data_out=0, freeze=0, go to IDLE.
- EOI, evaluated every cycle in any state:
  - eoi_nonspecific clears the lowest-index set ISR bit. No effect if ISR = 0.
  - eoi_specific clears ISR[eoi_level].
  - Both asserted together: the specific clear is applied first, then the non-specific clear acts on the remaining bits.
- EOI and an ISR set in the same cycle: clears apply first, then the set, so the newly set bit always survives.
- ISR is never set while int_out=0 outside the PENDING to ACK1 transition.
- All outputs are registered.

Optional Feature:
- Macro: AUTO_EOI_EN.
- Defined:
  - Adds input port auto_eoi (1 bit, ICW4 AEOI).
  - When auto_eoi=1, the ISR bit for the latched level is cleared on the ACK2 rise, in the same cycle data_out_en drops.
  - A spurious cycle clears nothing.
- Undefined: the port is absent. ISR bits clear only by explicit EOI.

Test Plan:
- interrupt=8'h08, ISR=0, vector_base=5'b01000, full INTA pair -> int_out=1 until first fall; ISR=8'h08; clear_interrupt_request=8'h08 for exactly 1 cycle; data_out=8'h43 during second INTA; freeze low after second rise.
- ISR=8'h04, interrupt=8'h10 -> int_out stays 0. Then interrupt=8'h02 -> int_out=1, and after the sequence ISR=8'h06.
- PENDING with interrupt=8'h20, interrupt dropped to 8'h00 before first INTA -> ISR unchanged, no clear pulse, data_out=8'h47 with vector_base=5'b01000.
- ISR=8'h0A; eoi_nonspecific -> ISR=8'h08. eoi_specific with eoi_level=3 -> ISR=8'h00. Specific and non-specific together on ISR=8'h0A with level=3 -> ISR=8'h00.
- reset asserted during ACK2 with data_out_en=1 -> next cycle all outputs 0, state IDLE. A following request restarts cleanly.
- AUTO_EOI_EN defined, auto_eoi=1, interrupt=8'h01 -> ISR=8'h01 after first fall, ISR=8'h00 in the cycle of the second rise.

Source files
------------

// File: rtl/in_service_control.sv
// Purpose: 8259A in-service control: nested-priority INT, two-pulse 8086 INTA sequence, ISR set/EOI.
// Latency: INT one cycle after an eligible request; inta_n edges act INTA_SYNC_STAGES+1 cycles after the pin.
// Backpressure: none (no flow control); freeze tells the IRR stage to hold its contents. Optional: AUTO_EOI_EN.
module in_service_control #(
    parameter int INTA_SYNC_STAGES = 2,   // 2 or 3
    parameter int SPURIOUS_LEVEL   = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt,
    input  logic [4:0] vector_base,
    input  logic       inta_n,
    input  logic       eoi_nonspecific,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
`ifdef AUTO_EOI_EN
    input  logic       auto_eoi,
`endif
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [7:0] clear_interrupt_request,
    output logic       freeze,
    output logic [7:0] data_out,
    output logic       data_out_en
);

    localparam logic [2:0] SPUR_LVL = SPURIOUS_LEVEL[2:0];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK1    = 2'd2,
        ACK2    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [INTA_SYNC_STAGES-1:0] inta_sync;
    logic       inta_prev;
    logic       inta_cur;
    logic       inta_fall;
    logic       inta_rise;

    logic [2:0] req_level;
    logic [7:0] req_mask;
    logic       eligible;

    logic [2:0] latched_level, latched_level_nxt;
    logic       spurious, spurious_nxt;

    logic       int_nxt;
    logic [7:0] isr_nxt;
    logic [7:0] isr_set;
    logic [7:0] isr_auto_clr;
    logic [7:0] isr_after_spec;
    logic [7:0] isr_lowest;
    logic [7:0] clr_nxt;
    logic       freeze_nxt;
    logic [7:0] dout_nxt;
    logic       dout_en_nxt;

    // Index of the lowest set bit (the resolver delivers one-hot, so this is just the level).
    function automatic logic [2:0] lowest_level(input logic [7:0] v);
        lowest_level = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_level = i[2:0];
        end
    endfunction

    // Synchronise the asynchronous inta_n pin and keep one more flop for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            inta_sync <= '1;
            inta_prev <= 1'b1;
        end else begin
            inta_sync <= {inta_sync[INTA_SYNC_STAGES-2:0], inta_n};
            inta_prev <= inta_sync[INTA_SYNC_STAGES-1];
        end
    end

    assign inta_cur  = inta_sync[INTA_SYNC_STAGES-1];
    assign inta_fall = inta_prev & ~inta_cur;
    assign inta_rise = ~inta_prev & inta_cur;

    // Fully nested: a request is blocked by any in-service level of equal or higher priority.
    assign req_level = lowest_level(interrupt);
    assign req_mask  = 8'hFF >> (3'd7 - req_level);
    assign eligible  = (interrupt != 8'h00) && ((in_service_register & req_mask) == 8'h00);

    // Next-state and next registered-output values for the INTA sequencer.
    always_comb begin
        state_nxt         = state;
        int_nxt           = int_out;
        clr_nxt           = 8'h00;
        freeze_nxt        = freeze;
        dout_nxt          = data_out;
        dout_en_nxt       = data_out_en;
        latched_level_nxt = latched_level;
        spurious_nxt      = spurious;
        isr_set           = 8'h00;
        isr_auto_clr      = 8'h00;

        case (state)
            IDLE: begin
                if (eligible) begin
                    state_nxt = PENDING;
                    int_nxt   = 1'b1;
                end
            end
            PENDING: begin
                // The request is deliberately not rechecked; only the first INTA ends this state.
                if (inta_fall) begin
                    state_nxt  = ACK1;
                    int_nxt    = 1'b0;
                    freeze_nxt = 1'b1;
                    if (interrupt != 8'h00) begin
                        latched_level_nxt = req_level;
                        spurious_nxt      = 1'b0;
                        isr_set           = 8'd1 << req_level;
                        clr_nxt           = 8'd1 << req_level;
                    end else begin
                        latched_level_nxt = SPUR_LVL;
                        spurious_nxt      = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_rise) state_nxt = ACK2;
            end
            ACK2: begin
                if (inta_fall) begin
                    dout_nxt    = {vector_base, latched_level};
                    dout_en_nxt = 1'b1;
                end else if (inta_rise) begin
                    dout_nxt    = 8'h00;
                    dout_en_nxt = 1'b0;
                    freeze_nxt  = 1'b0;
                    state_nxt   = IDLE;
`ifdef AUTO_EOI_EN
                    if (auto_eoi && !spurious) isr_auto_clr = 8'd1 << latched_level;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ISR update order: specific EOI, then non-specific on what remains, then auto-EOI, then the new set.
    always_comb begin
        isr_after_spec = in_service_register;
        if (eoi_specific) isr_after_spec[eoi_level] = 1'b0;
        isr_lowest = isr_after_spec & (~isr_after_spec + 8'd1);
        isr_nxt    = isr_after_spec;
        if (eoi_nonspecific) isr_nxt = isr_after_spec & ~isr_lowest;
        isr_nxt = (isr_nxt & ~isr_auto_clr) | isr_set;
    end

    // State and output registers; reset aborts any sequence in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            int_out                 <= 1'b0;
            in_service_register     <= 8'h00;
            clear_interrupt_request <= 8'h00;
            freeze                  <= 1'b0;
            data_out                <= 8'h00;
            data_out_en             <= 1'b0;
            latched_level           <= 3'd0;
            spurious                <= 1'b0;
        end else begin
            state                   <= state_nxt;
            int_out                 <= int_nxt;
            in_service_register     <= isr_nxt;
            clear_interrupt_request <= clr_nxt;
            freeze                  <= freeze_nxt;
            data_out                <= dout_nxt;
            data_out_en             <= dout_en_nxt;
            latched_level           <= latched_level_nxt;
            spurious                <= spurious_nxt;
        end
    end

endmodule

// File: tb/tb_in_service_control.sv
// Purpose: self-checking bench for in_service_control against a priority/ISR reference model.
// Latency: checks at settled points several cycles after each inta_n change.
// Backpressure: not applicable; stimulus is directed steps followed by randomized sequences.
module tb_in_service_control;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] interrupt;
    logic [4:0] vector_base;
    logic       inta_n;
    logic       eoi_nonspecific;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       auto_eoi;
    logic       int_out;
    logic [7:0] in_service_register;
    logic [7:0] clear_interrupt_request;
    logic       freeze;
    logic [7:0] data_out;
    logic       data_out_en;

    int tests  = 0;
    int failed = 0;

    logic [7:0] ref_isr;
    int         clr_cnt;
    logic [7:0] clr_seen;

    always #5 clock = ~clock;

    in_service_control dut (
        .clock                   (clock),
        .reset                   (reset),
        .interrupt               (interrupt),
        .vector_base             (vector_base),
        .inta_n                  (inta_n),
        .eoi_nonspecific         (eoi_nonspecific),
        .eoi_specific            (eoi_specific),
        .eoi_level               (eoi_level),
`ifdef AUTO_EOI_EN
        .auto_eoi                (auto_eoi),
`endif
        .int_out                 (int_out),
        .in_service_register     (in_service_register),
        .clear_interrupt_request (clear_interrupt_request),
        .freeze                  (freeze),
        .data_out                (data_out),
        .data_out_en             (data_out_en)
    );

    task automatic tick();
        @(posedge clock);
        #1;
        if (clear_interrupt_request != 8'h00) begin
            clr_cnt++;
            clr_seen |= clear_interrupt_request;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Reference model: level of a request and nested-priority eligibility.
    function automatic logic [2:0] lvl_of(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic bit is_eligible(input logic [7:0] req, input logic [7:0] isr);
        if (req == 8'h00) return 1'b0;
        for (int i = 0; i <= int'(lvl_of(req)); i++) if (isr[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] apply_eoi(input logic [7:0] isr, input bit spec,
                                             input logic [2:0] lvl, input bit ns);
        logic [7:0] r;
        r = isr;
        if (spec) r[lvl] = 1'b0;
        if (ns) begin
            for (int i = 0; i < 8; i++) begin
                if (r[i]) begin
                    r[i] = 1'b0;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic do_eoi(input bit spec, input logic [2:0] lvl, input bit ns);
        eoi_specific    = spec;
        eoi_level       = lvl;
        eoi_nonspecific = ns;
        ref_isr = apply_eoi(ref_isr, spec, lvl, ns);
        tick();
        eoi_specific    = 1'b0;
        eoi_nonspecific = 1'b0;
        check("isr_after_eoi", in_service_register, ref_isr);
        tick();
    endtask

    // One request plus (if eligible) the full INTA pair; drop=1 withdraws the request before INTA.
    task automatic do_seq(input logic [7:0] req, input logic [4:0] vb, input bit drop, input bit aeoi);
        bit         elig;
        logic [2:0] lvl;
        vector_base = vb;
        auto_eoi    = aeoi;
        interrupt   = req;
        elig = is_eligible(req, ref_isr);
        tick();
        tick();
        check("int_raise", {7'd0, int_out}, {7'd0, elig});
        if (!elig) begin
            interrupt = 8'h00;
            tick();
            return;
        end
        if (drop) interrupt = 8'h00;
        tick();
        check("int_hold", {7'd0, int_out}, 8'h01);

        clr_cnt  = 0;
        clr_seen = 8'h00;
        inta_n   = 1'b0;
        repeat (6) tick();
        if (!drop) ref_isr = ref_isr | req;
        lvl = drop ? 3'd7 : lvl_of(req);
        check("int_drop_on_inta", {7'd0, int_out}, 8'h00);
        check("freeze_set", {7'd0, freeze}, 8'h01);
        check("isr_after_inta1", in_service_register, ref_isr);
        check("clr_pulse_cycles", clr_cnt[7:0], drop ? 8'd0 : 8'd1);
        check("clr_pulse_value", clr_seen, drop ? 8'h00 : req);
        interrupt = 8'h00;

        inta_n = 1'b1;
        repeat (6) tick();
        check("no_drive_ack1", {7'd0, data_out_en}, 8'h00);

        inta_n = 1'b0;
        repeat (6) tick();
        check("drive_en_ack2", {7'd0, data_out_en}, 8'h01);
        check("vector", data_out, {vb, lvl});
        check("freeze_ack2", {7'd0, freeze}, 8'h01);

        inta_n = 1'b1;
        if (aeoi && !drop) ref_isr[lvl] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (data_out_en == 1'b0) break;
        end
        check("isr_at_inta2_rise", in_service_register, ref_isr);
        repeat (3) tick();
        check("drive_off", {7'd0, data_out_en}, 8'h00);
        check("data_cleared", data_out, 8'h00);
        check("freeze_cleared", {7'd0, freeze}, 8'h00);
        check("int_idle", {7'd0, int_out}, 8'h00);
    endtask

    initial begin
        bit aeoi_on;
`ifdef AUTO_EOI_EN
        aeoi_on = 1'b1;
`else
        aeoi_on = 1'b0;
`endif
        reset           = 1'b1;
        interrupt       = 8'h00;
        vector_base     = 5'd0;
        inta_n          = 1'b1;
        eoi_nonspecific = 1'b0;
        eoi_specific    = 1'b0;
        eoi_level       = 3'd0;
        auto_eoi        = 1'b0;
        ref_isr         = 8'h00;
        clr_cnt         = 0;
        clr_seen        = 8'h00;
        repeat (3) tick();
        check("rst_int", {7'd0, int_out}, 8'h00);
        check("rst_isr", in_service_register, 8'h00);
        check("rst_clr", clear_interrupt_request, 8'h00);
        check("rst_freeze", {7'd0, freeze}, 8'h00);
        check("rst_dout", data_out, 8'h00);
        check("rst_dout_en", {7'd0, data_out_en}, 8'h00);
        reset = 1'b0;
        repeat (4) tick();

        // Level 3 request, vector 0x43.
        do_seq(8'h08, 5'b01000, 1'b0, 1'b0);
        do_eoi(1'b1, 3'd3, 1'b0);

        // Nested priority: ISR=04 blocks level 4, level 1 gets through.
        do_seq(8'h04, 5'b01000, 1'b0, 1'b0);
        do_seq(8'h10, 5'b01000, 1'b0, 1'b0);
        do_seq(8'h02, 5'b01000, 1'b0, 1'b0);
        check("isr_nested", in_service_register, 8'h06);
        do_eoi(1'b0, 3'd0, 1'b1);
        do_eoi(1'b0, 3'd0, 1'b1);

        // Spurious: request withdrawn before the first INTA.
        do_seq(8'h20, 5'b01000, 1'b1, 1'b0);

        // EOI forms on ISR=0A.
        do_seq(8'h08, 5'b01000, 1'b0, 1'b0);
        do_seq(8'h02, 5'b01000, 1'b0, 1'b0);
        do_eoi(1'b0, 3'd0, 1'b1);
        do_eoi(1'b1, 3'd3, 1'b0);
        do_eoi(1'b0, 3'd0, 1'b1);
        do_seq(8'h08, 5'b01000, 1'b0, 1'b0);
        do_seq(8'h02, 5'b01000, 1'b0, 1'b0);
        do_eoi(1'b1, 3'd3, 1'b1);

        // Auto-EOI on level 0 (only active when the feature is built in).
        do_seq(8'h01, 5'b10101, 1'b0, aeoi_on);
        ref_isr = apply_eoi(ref_isr, 1'b1, 3'd0, 1'b0);
        do_eoi(1'b1, 3'd0, 1'b0);

        // Reset while the vector is on the bus.
        interrupt = 8'h10;
        tick();
        tick();
        inta_n = 1'b0;
        repeat (6) tick();
        interrupt = 8'h00;
        inta_n = 1'b1;
        repeat (6) tick();
        inta_n = 1'b0;
        repeat (6) tick();
        check("pre_rst_drive", {7'd0, data_out_en}, 8'h01);
        reset = 1'b1;
        tick();
        check("mid_rst_int", {7'd0, int_out}, 8'h00);
        check("mid_rst_isr", in_service_register, 8'h00);
        check("mid_rst_clr", clear_interrupt_request, 8'h00);
        check("mid_rst_freeze", {7'd0, freeze}, 8'h00);
        check("mid_rst_dout", data_out, 8'h00);
        check("mid_rst_dout_en", {7'd0, data_out_en}, 8'h00);
        reset   = 1'b0;
        ref_isr = 8'h00;
        repeat (4) tick();
        inta_n = 1'b1;
        repeat (6) tick();
        check("post_rst_idle", {7'd0, data_out_en}, 8'h00);
        do_seq(8'h10, 5'b00110, 1'b0, 1'b0);

        // Randomized requests, withdrawals and EOIs against the model.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] req;
            req = ($urandom_range(0, 4) == 0) ? 8'h00 : (8'd1 << $urandom_range(0, 7));
            do_seq(req, 5'($urandom), ($urandom_range(0, 3) == 0),
                   aeoi_on && ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 2) != 0)
                do_eoi(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
